// File: rtl/fetch_byte_queue.sv
// fetch_byte_queue: byte-granular instruction queue between aligned fetch responses and a 15-byte decode window.
// A redirect flushes the queue; a response already in flight is dropped by the DRAIN state.
module fetch_byte_queue #(
    parameter int FETCH_BYTES = 8,
    parameter int BUF_BYTES   = 32,
    parameter int WIN_BYTES   = 15
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       redirect,
    input  logic [63:0]                redirect_pc,
    output logic                       fetch_req,
    output logic [63:0]                fetch_addr,
    input  logic                       fetch_gnt,
    input  logic                       fetch_rvalid,
    input  logic [8*FETCH_BYTES-1:0]   fetch_rdata,
    output logic                       win_valid,
    output logic [3:0]                 win_count,
    output logic [63:0]                win_pc,
    output logic [0:8*WIN_BYTES-1]     win_bytes,
    input  logic                       consume,
    input  logic [3:0]                 consume_len,
    output logic                       consume_err
);
    localparam int PW = $clog2(BUF_BYTES);
    localparam int CW = $clog2(BUF_BYTES + 1);
    localparam int OW = $clog2(FETCH_BYTES);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DRAIN} state_t;

    state_t        r_state;
    logic [7:0]    r_buf [BUF_BYTES];
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [63:0]   r_win_pc;
    logic [63:0]   r_next_fetch;
    logic          r_first;
    logic [OW-1:0] r_off;
    logic          r_consume_err;

    logic          w_gnt;
    logic          w_wr;
    logic          w_legal;
    logic [OW-1:0] w_off;
    logic [CW-1:0] w_written;
    logic [CW-1:0] w_len;
    logic [PW-1:0] w_widx [FETCH_BYTES];

    assign fetch_req   = (r_state == REQ) && (r_count <= CW'(BUF_BYTES - FETCH_BYTES));
    assign fetch_addr  = r_next_fetch;
    assign win_count   = (r_count >= CW'(WIN_BYTES)) ? 4'(WIN_BYTES) : r_count[3:0];
    assign win_valid   = win_count != 4'd0;
    assign win_pc      = r_win_pc;
    assign consume_err = r_consume_err;

    assign w_gnt     = fetch_req && fetch_gnt;
    assign w_wr      = (r_state == WAIT) && fetch_rvalid && !redirect;
    assign w_legal   = consume && (consume_len != 4'd0) && (consume_len <= win_count);
    assign w_off     = r_first ? r_off : '0;
    assign w_written = w_wr ? CW'(FETCH_BYTES) - CW'(w_off) : '0;
    assign w_len     = CW'(consume_len);

    // Byte k of the line lands right after the current tail, skipping bytes below the redirect offset.
    always_comb begin
        for (int k = 0; k < FETCH_BYTES; k++)
            w_widx[k] = r_rd_ptr + PW'(r_count) + PW'(k) - PW'(w_off);
    end

    always_comb begin
        win_bytes = '0;
        for (int i = 0; i < WIN_BYTES; i++)
            win_bytes[8*i +: 8] = (4'(i) < win_count) ? r_buf[r_rd_ptr + PW'(i)] : 8'h00;
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < FETCH_BYTES; k++)
            if (w_wr && OW'(k) >= w_off)
                r_buf[w_widx[k]] <= fetch_rdata[8*k +: 8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_win_pc      <= '0;
            r_next_fetch  <= '0;
            r_first       <= 1'b0;
            r_off         <= '0;
            r_consume_err <= 1'b0;
        end else begin
            r_consume_err <= consume && !w_legal && !redirect;
            if (redirect) begin
                r_count      <= '0;
                r_win_pc     <= redirect_pc;
                r_next_fetch <= redirect_pc & ~64'(FETCH_BYTES - 1);
                r_first      <= 1'b1;
                r_off        <= redirect_pc[OW-1:0];
                r_state      <= (r_state == DRAIN || (r_state == WAIT && !fetch_rvalid) || w_gnt) ? DRAIN : REQ;
            end else begin
                r_count <= r_count - (w_legal ? w_len : '0) + w_written;
                if (w_legal) begin
                    r_rd_ptr <= r_rd_ptr + PW'(consume_len);
                    r_win_pc <= r_win_pc + 64'(consume_len);
                end
                if (w_wr)
                    r_first <= 1'b0;
                if (w_gnt) begin
                    r_state      <= WAIT;
                    r_next_fetch <= r_next_fetch + 64'(FETCH_BYTES);
                end
                if ((r_state == WAIT || r_state == DRAIN) && fetch_rvalid)
                    r_state <= REQ;
            end
        end
    end
endmodule
